audio_rx_scheduler: RTL and testbench

Controller for the 16-bit serial audio receiver that sequences it and decouples it from playback. The block drives the receiver's `active` input and absorbs its `data_ready`/`audio_out` words into an internal FIFO. It releases samples at a fixed sample-rate tick derived from the 25 MHz system clock. A watchdog re-frames the receiver when the word stream stalls, and the block reports underrun/overrun.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/audio_sample_fifo.sv | 65 ++++++
 rtl/audio_rx_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_audio_rx_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio receive scheduler and its sample FIFO.
package audio_pkg;

    localparam int AUDIO_W     = 16;
    localparam int RESYNC_HOLD = 2;
    localparam int HOLD_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_PLAY   = 2'd2,
        ST_RESYNC = 2'd3
    } sched_state_t;

    // States in which the receiver is running and words are accepted.
    function automatic logic is_rx_state(input sched_state_t s);
        return (s == ST_FILL) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock sample FIFO: pointers carry one wrap bit so level = wr - rd distinguishes full from empty.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign level = wr_ptr_r - rd_ptr_r;
    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Guard against pushing into a full FIFO or popping an empty one.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Pointer update; flush empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write; a write at full lands on the slot being read this cycle, whose old value is already on rdata.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/audio_rx_scheduler.sv
// Sequences the serial audio receiver, buffers its words and releases them at the sample-rate tick.
// Build option: AUDIO_SCHED_UNDERRUN_HOLD_EN holds the last sample on underrun instead of emitting silence.
module audio_rx_scheduler
    import audio_pkg::*;
#(
    parameter int clock_max     = 25_000_000,
    parameter int sample_rate   = 48_000,
    parameter int FIFO_DEPTH    = 16,
    parameter int RESYNC_CYCLES = 2_500
) (
    input  logic                          clk_25mhz,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rx_data_ready,
    input  logic [AUDIO_W-1:0]            rx_audio,
    output logic                          rx_active,
    output logic                          sample_tick,
    output logic [AUDIO_W-1:0]            sample_out,
    output logic                          sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overrun,
    output logic                          resync
);

    localparam int DIV    = clock_max / sample_rate;
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WD_W   = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(RESYNC_CYCLES - 1);
    localparam logic [LVL_W-1:0]  HALF_LVL  = LVL_W'(FIFO_DEPTH / 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESYNC_HOLD - 1);

    sched_state_t        state_r, next_state_s;
    logic [TICK_W-1:0]   tick_cnt_r, tick_cnt_next_s;
    logic [WD_W-1:0]     wd_cnt_r, wd_cnt_next_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_next_s;

    logic                rx_active_r, sample_tick_r, sample_valid_r;
    logic                underrun_r, overrun_r, resync_r;
    logic [AUDIO_W-1:0]  sample_out_r, sample_next_s, underrun_sample_s;

    logic                in_rx_s, trip_s, level_ok_s;
    logic                pop_req_s, push_req_s, overrun_s, flush_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [AUDIO_W-1:0]  fifo_rdata_s;
    logic [LVL_W-1:0]    fifo_level_s;

    audio_sample_fifo #(
        .WIDTH (AUDIO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_25mhz),
        .reset (reset),
        .flush (flush_s),
        .push  (push_req_s),
        .pop   (pop_req_s),
        .wdata (rx_audio),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

`ifdef AUDIO_SCHED_UNDERRUN_HOLD_EN
    assign underrun_sample_s = sample_out_r;
`else
    assign underrun_sample_s = {AUDIO_W{1'b0}};
`endif

    // Next-state logic; a dropped enable overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if (!enable) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: next_state_s = ST_FILL;
                ST_FILL: begin
                    if (trip_s) begin
                        next_state_s = ST_RESYNC;
                    end else if (level_ok_s) begin
                        next_state_s = ST_PLAY;
                    end else begin
                        next_state_s = ST_FILL;
                    end
                end
                ST_PLAY: begin
                    if (trip_s) begin
                        next_state_s = ST_RESYNC;
                    end else begin
                        next_state_s = ST_PLAY;
                    end
                end
                ST_RESYNC: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        next_state_s = level_ok_s ? ST_PLAY : ST_FILL;
                    end else begin
                        next_state_s = ST_RESYNC;
                    end
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // FIFO policy, watchdog and counter next values; the pop acts on the tick registered last cycle.
    always_comb begin
        in_rx_s     = is_rx_state(state_r);
        trip_s      = in_rx_s && (wd_cnt_r == WD_LAST);
        level_ok_s  = (fifo_level_s >= HALF_LVL);
        pop_req_s   = (state_r == ST_PLAY) && sample_tick_r && enable;
        push_req_s  = in_rx_s && rx_data_ready && enable;
        overrun_s   = push_req_s && fifo_full_s && !pop_req_s;
        flush_s     = !enable || (state_r == ST_IDLE);

        if (pop_req_s) begin
            sample_next_s = fifo_empty_s ? underrun_sample_s : fifo_rdata_s;
        end else begin
            sample_next_s = sample_out_r;
        end

        if ((next_state_s == ST_IDLE) || (next_state_s == ST_FILL)) begin
            tick_cnt_next_s = '0;
        end else if ((state_r == ST_PLAY) && (next_state_s == ST_PLAY)) begin
            tick_cnt_next_s = (tick_cnt_r == TICK_LAST) ? '0 : tick_cnt_r + TICK_W'(1);
        end else begin
            tick_cnt_next_s = tick_cnt_r;
        end

        if (in_rx_s && is_rx_state(next_state_s) && !rx_data_ready) begin
            wd_cnt_next_s = wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_next_s = '0;
        end

        if ((state_r == ST_RESYNC) && (next_state_s == ST_RESYNC)) begin
            hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_next_s = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_25mhz) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            tick_cnt_r     <= '0;
            wd_cnt_r       <= '0;
            hold_cnt_r     <= '0;
            rx_active_r    <= 1'b0;
            sample_tick_r  <= 1'b0;
            sample_out_r   <= {AUDIO_W{1'b0}};
            sample_valid_r <= 1'b0;
            underrun_r     <= 1'b0;
            overrun_r      <= 1'b0;
            resync_r       <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            tick_cnt_r     <= tick_cnt_next_s;
            wd_cnt_r       <= wd_cnt_next_s;
            hold_cnt_r     <= hold_cnt_next_s;
            rx_active_r    <= is_rx_state(next_state_s);
            sample_tick_r  <= (state_r == ST_PLAY) && (next_state_s == ST_PLAY) && (tick_cnt_r == TICK_LAST);
            sample_out_r   <= sample_next_s;
            sample_valid_r <= pop_req_s;
            underrun_r     <= pop_req_s && fifo_empty_s;
            overrun_r      <= overrun_s;
            resync_r       <= trip_s && enable;
        end
    end

    assign rx_active    = rx_active_r;
    assign sample_tick  = sample_tick_r;
    assign sample_out   = sample_out_r;
    assign sample_valid = sample_valid_r;
    assign fifo_level   = fifo_level_s;
    assign underrun     = underrun_r;
    assign overrun      = overrun_r;
    assign resync       = resync_r;

endmodule

// File: tb/tb_audio_rx_scheduler.sv
// Self-checking bench for audio_rx_scheduler: directed test-plan scenarios followed by random traffic,
// checked against a queue-based behavioural model and a sample scoreboard.
module tb_audio_rx_scheduler;

    localparam int CLK_MAX = 1000;
    localparam int SRATE   = 100;
    localparam int DEPTH   = 4;
    localparam int RC      = 50;
    localparam int DIV     = CLK_MAX / SRATE;
    localparam int LW      = $clog2(DEPTH) + 1;

    localparam int MD_IDLE = 0;
    localparam int MD_FILL = 1;
    localparam int MD_PLAY = 2;
    localparam int MD_RSYN = 3;

    logic          clk_25mhz = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          rx_data_ready = 1'b0;
    logic [15:0]   rx_audio = 16'h0000;
    logic          rx_active;
    logic          sample_tick;
    logic [15:0]   sample_out;
    logic          sample_valid;
    logic [LW-1:0] fifo_level;
    logic          underrun;
    logic          overrun;
    logic          resync;

    audio_rx_scheduler #(
        .clock_max     (CLK_MAX),
        .sample_rate   (SRATE),
        .FIFO_DEPTH    (DEPTH),
        .RESYNC_CYCLES (RC)
    ) dut (
        .clk_25mhz     (clk_25mhz),
        .reset         (reset),
        .enable        (enable),
        .rx_data_ready (rx_data_ready),
        .rx_audio      (rx_audio),
        .rx_active     (rx_active),
        .sample_tick   (sample_tick),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .fifo_level    (fifo_level),
        .underrun      (underrun),
        .overrun       (overrun),
        .resync        (resync)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        u;
    } exp_t;
    exp_t sb[$];

    // Reference model state: the buffer is a plain queue, time in PLAY is counted in clocks.
    int          m_mode = MD_IDLE;
    logic [15:0] m_q[$];
    int          m_quiet = 0;
    int          m_play_clks = 0;
    int          m_rsyn_clks = 0;
    logic        e_rx_active = 1'b0;
    logic        e_tick = 1'b0;
    logic [15:0] e_sample = 16'h0000;
    logic        e_underrun = 1'b0;
    logic        e_overrun = 1'b0;
    logic        e_resync = 1'b0;
    int          e_level = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s at %0t: got %h, wanted %h", name, $time, act, exp);
            end
        end
    endtask

    // Advance the model by one clock from the inputs present before the edge.
    task automatic model_step();
        int   held;
        int   nxt;
        logic receiving;
        logic stalled;
        logic tick_due;
        logic popped;
        if (!reset) begin
            m_mode = MD_IDLE;
            m_q.delete();
            m_quiet = 0;
            m_play_clks = 0;
            m_rsyn_clks = 0;
            e_rx_active = 1'b0;
            e_tick = 1'b0;
            e_sample = 16'h0000;
            e_underrun = 1'b0;
            e_overrun = 1'b0;
            e_resync = 1'b0;
            e_level = 0;
        end else begin
            held      = m_q.size();
            receiving = (m_mode == MD_FILL) || (m_mode == MD_PLAY);
            stalled   = receiving && (m_quiet == RC - 1);
            tick_due  = (m_mode == MD_PLAY) && e_tick && enable;
            if (!enable) nxt = MD_IDLE;
            else if (m_mode == MD_IDLE) nxt = MD_FILL;
            else if (stalled) nxt = MD_RSYN;
            else if (m_mode == MD_FILL) nxt = (held >= DEPTH / 2) ? MD_PLAY : MD_FILL;
            else if (m_mode == MD_PLAY) nxt = MD_PLAY;
            else if (m_rsyn_clks + 1 >= 2) nxt = (held >= DEPTH / 2) ? MD_PLAY : MD_FILL;
            else nxt = MD_RSYN;

            e_underrun = 1'b0;
            e_overrun  = 1'b0;
            popped     = 1'b0;
            if (tick_due) begin
                if (held > 0) begin
                    e_sample = m_q.pop_front();
                    popped = 1'b1;
                end else begin
                    e_underrun = 1'b1;
`ifndef AUDIO_SCHED_UNDERRUN_HOLD_EN
                    e_sample = 16'h0000;
`endif
                end
                sb.push_back({e_sample, e_underrun});
            end
            if (receiving && rx_data_ready && enable) begin
                if (held < DEPTH || popped) m_q.push_back(rx_audio);
                else e_overrun = 1'b1;
            end
            if (!enable) m_q.delete();

            e_resync = stalled && enable;
            if (m_mode == MD_PLAY && nxt == MD_PLAY) begin
                m_play_clks++;
                e_tick = (m_play_clks % DIV == 0);
            end else begin
                e_tick = 1'b0;
            end
            if (nxt == MD_IDLE || nxt == MD_FILL) m_play_clks = 0;
            m_quiet     = (receiving && (nxt == MD_FILL || nxt == MD_PLAY) && !rx_data_ready) ? m_quiet + 1 : 0;
            m_rsyn_clks = (nxt == MD_RSYN && m_mode == MD_RSYN) ? m_rsyn_clks + 1 : 0;
            e_rx_active = (nxt == MD_FILL) || (nxt == MD_PLAY);
            m_mode      = nxt;
            e_level     = m_q.size();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_25mhz);
            model_step();
        end
    end

    // Monitor: per-cycle status compare plus scoreboard pop on every sample_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_25mhz);
            check("rx_active",   int'(rx_active),   int'(e_rx_active));
            check("sample_tick", int'(sample_tick), int'(e_tick));
            check("fifo_level",  int'(fifo_level),  e_level);
            check("underrun",    int'(underrun),    int'(e_underrun));
            check("overrun",     int'(overrun),     int'(e_overrun));
            check("resync",      int'(resync),      int'(e_resync));
            check("sample_out",  int'(sample_out),  int'(e_sample));
            if (sample_valid) begin
                if (sb.size() == 0) begin
                    check("valid_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_sample",   int'(sample_out), int'(e.s));
                    check("sb_underrun", int'(underrun),   int'(e.u));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #2;
        end
    endtask

    task automatic strobe(input logic [15:0] d);
        rx_data_ready = 1'b1;
        rx_audio = d;
        cyc(1);
        rx_data_ready = 1'b0;
        rx_audio = 16'($urandom);
    endtask

    // Wait for a model event: 0 = tick cycle, 1 = resync cycle, 2 = watchdog one clock from tripping.
    task automatic wait_for(input int which, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (which)
                0: hit = e_tick;
                1: hit = e_resync;
                default: hit = (m_quiet == RC - 1) && (m_mode == MD_FILL || m_mode == MD_PLAY);
            endcase
            if (hit) break;
            cyc(1);
        end
        if (!hit) check("wait_timeout", which, -1);
    endtask

    initial begin
        int rate;
        int rates[5] = '{0, 3, 10, 30, 60};
        cyc(3);
        reset = 1'b1;
        cyc(2);

        // Fill and play, then underrun, then stall into RESYNC with strobes ignored.
        enable = 1'b1;
        cyc(1);
        strobe(16'h1111);
        strobe(16'h2222);
        wait_for(1, 90);
        strobe(16'hBEEF);
        cyc(3);

        // Fill to full, overrun with 0xAAAA, then a push coincident with a pop at full.
        strobe(16'h3333);
        strobe(16'h4444);
        strobe(16'h5555);
        strobe(16'h6666);
        strobe(16'hAAAA);
        wait_for(0, 30);
        strobe(16'h7777);
        cyc(5);

        // Stall that trips while a push lifts the level to the threshold: exits to PLAY.
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(1);
        strobe(16'h8888);
        wait_for(2, 80);
        strobe(16'h9999);
        cyc(6);

        // Disable with three words buffered.
        enable = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(1);
        strobe(16'hC001);
        strobe(16'hC002);
        strobe(16'hC003);
        enable = 1'b0;
        cyc(3);

        // Reset in the middle of PLAY.
        enable = 1'b1;
        cyc(1);
        strobe(16'hD001);
        strobe(16'hD002);
        strobe(16'hD003);
        cyc(12);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(3);

        // Random traffic with varying strobe density, enable drops and occasional resets.
        rate = 30;
        for (int i = 0; i < 2400; i++) begin
            if (i % 150 == 0) rate = rates[$urandom_range(0, 4)];
            if (enable) enable = ($urandom_range(0, 299) != 0);
            else enable = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 999) != 0);
            rx_data_ready = ($urandom_range(0, 99) < rate);
            rx_audio = 16'($urandom);
            cyc(1);
        end
        reset = 1'b1;
        rx_data_ready = 1'b0;
        enable = 1'b0;
        cyc(4);

        check("sb_leftover", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
